// File: rtl/spi_bubble_loader_pkg.sv
// spi_bubble_loader_pkg: opcodes, FSM states, boot page default and flash address packing
package spi_bubble_loader_pkg;
   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_FASTREAD = 8'h0B;
   localparam logic [11:0] BOOT_PAGE_DEF = 12'h805;
   typedef enum logic [2:0] {IDLE, CMD, DUMMY, BOOT, MAP, LEAD, PAGE, FINISH} state_t;
   function automatic logic [23:0] flash_addr(input logic [23:0] img, input logic [23:0] page, input int page_w);
      return ((img << page_w) | page) << 7;
   endfunction
endpackage

// File: rtl/spi_bubble_loader_spi_bit_engine.sv
// spi_bit_engine: mode-3 SPI shifter, MOSI changes on CLK fall, MISO captured on the edge raising CLK
module spi_bit_engine #(
   parameter int CLK_DIV = 2
) (
   input  logic        MCLK,
   input  logic        nRESET,
   input  logic        start,
   input  logic [5:0]  len,
   input  logic [39:0] tx,
   output logic        bit_valid,
   output logic        rx_bit,
   output logic        busy,
   output logic        CLK,
   output logic        MOSI,
   input  logic        MISO
);
   localparam int DW = $clog2(CLK_DIV + 1);
   logic [DW-1:0] div;
   logic [5:0] left;
   logic [39:0] sh;
   // half-period timer drives CLK; each rising edge samples one bit and counts it off
   always_ff @(posedge MCLK or negedge nRESET)
      if (!nRESET) begin
         busy <= 1'b0;
         CLK <= 1'b1;
         MOSI <= 1'b0;
         rx_bit <= 1'b0;
         bit_valid <= 1'b0;
         sh <= '0;
         left <= '0;
         div <= '0;
      end else begin
         bit_valid <= 1'b0;
         if (start && !busy) begin
            busy <= 1'b1;
            CLK <= 1'b0;
            MOSI <= tx[39];
            sh <= {tx[38:0], 1'b0};
            left <= len;
            div <= '0;
         end else if (busy) begin
            if (div == DW'(CLK_DIV - 1)) begin
               div <= '0;
               if (!CLK) begin
                  CLK <= 1'b1;
                  rx_bit <= MISO;
                  bit_valid <= 1'b1;
                  left <= left - 1'b1;
               end else if (left == 6'd0) busy <= 1'b0;
               else begin
                  CLK <= 1'b0;
                  MOSI <= sh[39];
                  sh <= {sh[38:0], 1'b0};
               end
            end else div <= div + 1'b1;
         end
      end
endmodule

// File: rtl/spi_bubble_loader.sv
// spi_bubble_loader: loads bootloader, bad-loop map and map-expanded pages from SPI flash into the bubble buffer
// Build option SPI_FASTREAD_EN: FAST READ opcode with 8 dummy clocks after the address.
module spi_bubble_loader
   import spi_bubble_loader_pkg::*;
#(
   parameter int IMG_W = 3,
   parameter int PAGE_W = 12,
   parameter int NUM_PAGES = 2053,
   parameter logic [PAGE_W-1:0] BOOT_PAGE = PAGE_W'(BOOT_PAGE_DEF),
   parameter int BOOT_BITS = 2048,
   parameter int MAP_LEN = 584,
   parameter int LEAD_ZEROS = 6,
   parameter int GOOD_LOOPS = 518,
   parameter int CLK_DIV = 2,
   parameter int BUFADDR_W = 15
) (
   input  logic                 MCLK,
   input  logic                 nRESET,
   input  logic [IMG_W-1:0]     IMGNUM,
   input  logic                 REQ_BOOT,
   input  logic                 REQ_PAGE,
   input  logic [PAGE_W-1:0]    PAGENUM,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 ERR,
   output logic                 MAP_VALID,
   output logic [BUFADDR_W-1:0] BUFWADDR,
   output logic                 BUFWCLK,
   output logic                 BUFWDATA,
   output logic                 nCS,
   output logic                 CLK,
   output logic                 MOSI,
   input  logic                 MISO
);
`ifdef SPI_FASTREAD_EN
   localparam logic [7:0] OPCODE = OP_FASTREAD;
`else
   localparam logic [7:0] OPCODE = OP_READ;
`endif
   // depth rounded to whole nibbles so nibble-reversed writes stay in range
   localparam int MAP_DEPTH = (MAP_LEN + 15) / 16 * 16;
   localparam int PW = $clog2(MAP_DEPTH);
   localparam int CW = $clog2(BOOT_BITS + 1);
   localparam int GW = $clog2(GOOD_LOOPS + 1);
   state_t state;
   logic [1:0] wst;
   logic [CW-1:0] cnt;
   logic [PW-1:0] pos;
   logic [GW-1:0] good;
   logic boot;
   logic eng_start, eng_valid, eng_rx, eng_busy, eng_done, map_bit, need_flash, map_we;
   logic [5:0] eng_len;
   logic [39:0] eng_tx;
   logic map_ram [MAP_DEPTH];
   assign eng_done = !eng_start && !eng_busy;
   assign map_bit = map_ram[pos];
   assign need_flash = state == BOOT || state == MAP || (state == PAGE && map_bit);
   assign map_we = state == MAP && wst == 2'd3;
   spi_bit_engine #(.CLK_DIV(CLK_DIV)) u_eng (
      .MCLK(MCLK), .nRESET(nRESET), .start(eng_start), .len(eng_len), .tx(eng_tx),
      .bit_valid(eng_valid), .rx_bit(eng_rx), .busy(eng_busy), .CLK(CLK), .MOSI(MOSI), .MISO(MISO)
   );
   // map table captured nibble-reversed while the map streams past; never reset
   always_ff @(posedge MCLK)
      if (map_we) map_ram[{pos[PW-1:4], ~pos[3:0]}] <= BUFWDATA;
   // request handling, command phase, per-bit buffer write sequencing and completion
   always_ff @(posedge MCLK or negedge nRESET)
      if (!nRESET) begin
         state <= IDLE;
         wst <= '0;
         cnt <= '0;
         pos <= '0;
         good <= '0;
         boot <= 1'b0;
         eng_start <= 1'b0;
         eng_len <= '0;
         eng_tx <= '0;
         nCS <= 1'b1;
         BUSY <= 1'b0;
         DONE <= 1'b0;
         ERR <= 1'b0;
         MAP_VALID <= 1'b0;
         BUFWADDR <= '0;
         BUFWCLK <= 1'b0;
         BUFWDATA <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         DONE <= 1'b0;
         ERR <= 1'b0;
         case (state)
            IDLE: if (REQ_BOOT || REQ_PAGE) begin
               if (!REQ_BOOT && (32'(PAGENUM) >= NUM_PAGES || !MAP_VALID)) ERR <= 1'b1;
               else begin
                  boot <= REQ_BOOT;
                  state <= CMD;
                  BUSY <= 1'b1;
                  nCS <= 1'b0;
                  BUFWADDR <= '0;
                  eng_start <= 1'b1;
                  eng_len <= 6'd32;
                  eng_tx <= {OPCODE, flash_addr(24'(IMGNUM), REQ_BOOT ? 24'(BOOT_PAGE) : 24'(PAGENUM), PAGE_W), 8'h00};
               end
            end
`ifdef SPI_FASTREAD_EN
            CMD: if (eng_done) begin
               state <= DUMMY;
               eng_start <= 1'b1;
               eng_len <= 6'd8;
               eng_tx <= '0;
            end
            DUMMY: if (eng_done) begin
               state <= boot ? BOOT : LEAD;
               eng_tx <= '0;
               cnt <= '0;
               pos <= '0;
               good <= '0;
               wst <= '0;
            end
`else
            CMD: if (eng_done) begin
               state <= boot ? BOOT : LEAD;
               eng_tx <= '0;
               cnt <= '0;
               pos <= '0;
               good <= '0;
               wst <= '0;
            end
`endif
            BOOT, MAP, LEAD, PAGE: case (wst)
               2'd0: if (!need_flash) begin
                  BUFWDATA <= 1'b0;
                  wst <= 2'd2;
               end else if (eng_done) begin
                  eng_start <= 1'b1;
                  eng_len <= 6'd1;
                  wst <= 2'd1;
               end
               2'd1: if (eng_valid) begin
                  BUFWDATA <= eng_rx;
                  wst <= 2'd2;
               end
               2'd2: begin
                  BUFWCLK <= 1'b1;
                  wst <= 2'd3;
               end
               default: begin
                  BUFWCLK <= 1'b0;
                  BUFWADDR <= BUFWADDR + 1'b1;
                  wst <= 2'd0;
                  if (state == BOOT) begin
                     cnt <= cnt + 1'b1;
                     if (cnt == CW'(BOOT_BITS - 1)) state <= MAP;
                  end else begin
                     pos <= pos + 1'b1;
                     if (state != MAP && map_bit) good <= good + 1'b1;
                     if (state == MAP && pos == PW'(MAP_LEN - 1)) begin
                        MAP_VALID <= 1'b1;
                        state <= FINISH;
                        nCS <= 1'b1;
                        cnt <= '0;
                     end else if (state == LEAD && map_bit && good == GW'(LEAD_ZEROS - 1)) state <= PAGE;
                     else if (pos == PW'(MAP_LEN - 1) || (state == PAGE && map_bit && good == GW'(GOOD_LOOPS - 1))) begin
                        state <= FINISH;
                        nCS <= 1'b1;
                        cnt <= '0;
                     end
                  end
               end
            endcase
            FINISH: if (cnt == CW'(CLK_DIV - 1)) begin
               DONE <= 1'b1;
               BUSY <= 1'b0;
               state <= IDLE;
            end else cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule
